// File: rtl/execute_stage.sv
// Execute stage of a 5-stage MIPS-style pipeline: operand forwarding, ALU,
// and a 32-cycle iterative shift-add multiplier feeding HI/LO.
module execute_stage #(
    parameter int FWD_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [135:0] IDEXReg,
    input  logic [70:0]  MEMWBReg,
    output logic [74:0]  EXMEReg,
    output logic         exStall,
    output logic [1:0]   dbgState
);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

    state_t state, nextState;

    // ID/EX field decode
    logic        regDst, memRead, memtoReg, memWrite, aluSrc, regWrite;
    logic [1:0]  aluOp;
    logic [31:0] imm, rtData, rsData, instr;
    logic [4:0]  rs, rt, rd, shamt, wreg;
    logic [5:0]  funct;
    logic        ctrlValid, isMult, isSigned;

    assign regDst    = IDEXReg[135];
    assign memRead   = IDEXReg[134];
    assign memtoReg  = IDEXReg[133];
    assign aluOp     = IDEXReg[132:131];
    assign memWrite  = IDEXReg[130];
    assign aluSrc    = IDEXReg[129];
    assign regWrite  = IDEXReg[128];
    assign imm       = IDEXReg[127:96];
    assign rtData    = IDEXReg[95:64];
    assign rsData    = IDEXReg[63:32];
    assign instr     = IDEXReg[31:0];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign shamt     = instr[10:6];
    assign funct     = instr[5:0];
    assign wreg      = regDst ? rd : rt;
    assign ctrlValid = (IDEXReg[135:128] != 8'd0);
    assign isMult    = (aluOp == 2'b10) && ((funct == 6'h18) || (funct == 6'h19));
    assign isSigned  = (funct == 6'h18);

    // Opcode bits are decoded upstream; the stage only needs the R-type fields.
    logic unusedOpcode;
    assign unusedOpcode = ^instr[31:26];

    // Forwarding sources: a load in EX/MEM has no data yet, so it never forwards.
    logic        exFwdOk, wbFwdOk;
    logic [31:0] wbVal, fwdA, fwdB;
    assign exFwdOk = EXMEReg[69] && !EXMEReg[71] && (EXMEReg[68:64] != 5'd0);
    assign wbFwdOk = MEMWBReg[37] && (MEMWBReg[36:32] != 5'd0);
    assign wbVal   = MEMWBReg[70] ? MEMWBReg[31:0] : MEMWBReg[69:38];

    // Operand selection with EX/MEM taking priority over MEM/WB
    always_comb begin
        fwdA = rsData;
        fwdB = rtData;
        if (FWD_EN != 0) begin
            if (exFwdOk && (EXMEReg[68:64] == rs))      fwdA = EXMEReg[31:0];
            else if (wbFwdOk && (MEMWBReg[36:32] == rs)) fwdA = wbVal;
            if (exFwdOk && (EXMEReg[68:64] == rt))      fwdB = EXMEReg[31:0];
            else if (wbFwdOk && (MEMWBReg[36:32] == rt)) fwdB = wbVal;
        end
    end

    logic [31:0] aluA, aluB, addRes, subRes, aluRes;
    logic        addOvf, subOvf, ovf, sltRes;
    assign aluA   = fwdA;
    assign aluB   = aluSrc ? imm : fwdB;
    assign addRes = aluA + aluB;
    assign subRes = aluA - aluB;
    assign addOvf = (aluA[31] == aluB[31]) && (addRes[31] != aluA[31]);
    assign subOvf = (aluA[31] != aluB[31]) && (subRes[31] != aluA[31]);
    assign sltRes = ($signed(aluA) < $signed(aluB));

    logic [31:0] hi, lo;

    // ALU result and signed-overflow flag (only add/sub can overflow)
    always_comb begin
        aluRes = 32'd0;
        ovf    = 1'b0;
        case (aluOp)
            2'b00: begin aluRes = addRes; ovf = addOvf; end
            2'b01: begin aluRes = subRes; ovf = subOvf; end
            2'b11: aluRes = {31'd0, sltRes};
            default: begin
                case (funct)
                    6'h20: begin aluRes = addRes; ovf = addOvf; end
                    6'h22: begin aluRes = subRes; ovf = subOvf; end
                    6'h24: aluRes = aluA & aluB;
                    6'h25: aluRes = aluA | aluB;
                    6'h2A: aluRes = {31'd0, sltRes};
                    6'h00: aluRes = aluB << shamt;
                    6'h10: aluRes = hi;
                    6'h12: aluRes = lo;
                    default: aluRes = 32'd0;
                endcase
            end
        endcase
    end

    // Multiplier works on magnitudes; the sign is reapplied once at DONE.
    logic [63:0] mcand, acc, product;
    logic [31:0] mplier, absA, absB;
    logic [4:0]  counter;
    logic        negate;
    assign absA    = (isSigned && fwdA[31]) ? (~fwdA + 32'd1) : fwdA;
    assign absB    = (isSigned && fwdB[31]) ? (~fwdB + 32'd1) : fwdB;
    assign product = negate ? (~acc + 64'd1) : acc;

    // Stall is forced low during reset so a pending MULT cannot hold the front end.
    assign exStall  = !reset && (((state == IDLE) && isMult) || (state == MUL));
    assign dbgState = state;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (isMult) nextState = MUL;
            MUL:     if (counter == 5'd31) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: EX/MEM capture, multiplier iterations and HI/LO update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EXMEReg <= 75'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            mcand   <= 64'd0;
            mplier  <= 32'd0;
            acc     <= 64'd0;
            negate  <= 1'b0;
            counter <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (isMult) begin
                        mcand   <= {32'd0, absA};
                        mplier  <= absB;
                        acc     <= 64'd0;
                        negate  <= isSigned && (fwdA[31] ^ fwdB[31]);
                        counter <= 5'd0;
                        EXMEReg <= 75'd0;
                    end else begin
                        EXMEReg <= {ovf, ctrlValid, memWrite, memRead, memtoReg,
                                    regWrite, wreg, fwdB, aluRes};
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + 5'd1;
                    EXMEReg <= 75'd0;
                end
                DONE: begin
                    hi      <= product[63:32];
                    lo      <= product[31:0];
                    EXMEReg <= {1'b0, 1'b1, memWrite, memRead, memtoReg,
                                1'b0, wreg, fwdB, product[31:0]};
                end
                default: EXMEReg <= 75'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, forwarding priority, overflow,
// multi-cycle MULT/MULTU with HI/LO readback, and reset during a multiply.
module tb_execute_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic [135:0] IDEXReg;
    logic [70:0]  MEMWBReg;
    logic [74:0]  EXMEReg;
    logic         exStall;
    logic [1:0]   dbgState;

    logic [74:0] exp_q[$];
    int          nTests = 0;
    int          nFail  = 0;

    localparam logic [7:0] CTRL_R    = 8'b1001_0001;
    localparam logic [7:0] CTRL_MULT = 8'b1001_0000;
    localparam logic [7:0] CTRL_ADDI = 8'b0000_0011;
    localparam logic [7:0] CTRL_LW   = 8'b0110_0011;
    localparam logic [7:0] CTRL_SLTI = 8'b0001_1011;

    execute_stage #(.FWD_EN(1)) dut (
        .clk(clk), .reset(reset), .IDEXReg(IDEXReg), .MEMWBReg(MEMWBReg),
        .EXMEReg(EXMEReg), .exStall(exStall), .dbgState(dbgState)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm16);
        return {op[5:0], rs[4:0], rt[4:0], imm16[15:0]};
    endfunction

    function automatic logic [135:0] idex(logic [7:0] ctrl, logic [31:0] imm,
                                          logic [31:0] rtD, logic [31:0] rsD,
                                          logic [31:0] ins);
        return {ctrl, imm, rtD, rsD, ins};
    endfunction

    function automatic logic [70:0] memwb(logic mtr, logic [31:0] alu, logic rw,
                                          int wr, logic [31:0] rdData);
        return {mtr, alu, rw, wr[4:0], rdData};
    endfunction

    function automatic logic [74:0] exme(logic ovf, logic vld, logic mw, logic mr,
                                         logic mtr, logic rw, int wr,
                                         logic [31:0] store, logic [31:0] res);
        return {ovf, vld, mw, mr, mtr, rw, wr[4:0], store, res};
    endfunction

    task automatic checkEq(string tag, logic [74:0] obs, logic [74:0] expv);
        nTests++;
        assert (obs === expv)
        else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle instruction: expect no stall, result on the next edge
    task automatic issue(string tag, logic [135:0] idv, logic [70:0] wbv, logic [74:0] expv);
        IDEXReg  = idv;
        MEMWBReg = wbv;
        exp_q.push_back(expv);
        #1;
        checkEq({tag, "_stall"}, exStall, 1'b0);
        tick();
        checkEq(tag, EXMEReg, exp_q.pop_front());
    endtask

    // Multiply: 33 stall cycles of bubbles, then a DONE capture
    task automatic runMult(string tag, logic [135:0] idv, logic [74:0] expDone);
        int n;
        IDEXReg  = idv;
        MEMWBReg = '0;
        exp_q.push_back(expDone);
        #1;
        n = 0;
        while (exStall && n < 40) begin
            tick();
            n++;
            checkEq({tag, "_bubble"}, EXMEReg, 75'd0);
            // Scramble MEM/WB while the product is being formed
            MEMWBReg = (n <= 31) ? {$urandom, $urandom, $urandom} : '0;
            #1;
        end
        checkEq({tag, "_stall_cycles"}, n, 33);
        checkEq({tag, "_done_state"}, dbgState, 2'd2);
        tick();
        checkEq({tag, "_done"}, EXMEReg, exp_q.pop_front());
    endtask

    initial begin
        // Reset with a MULT already waiting: stall must still read low
        reset    = 1'b1;
        MEMWBReg = '0;
        IDEXReg  = idex(CTRL_MULT, 0, 32'd7, 32'd3, rtype(18, 19, 0, 0, 'h18));
        #1;
        checkEq("reset_exme", EXMEReg, 75'd0);
        checkEq("reset_stall", exStall, 1'b0);
        tick();
        tick();
        IDEXReg = '0;
        reset   = 1'b0;
        #1;

        issue("add_basic", idex(CTRL_R, 0, 32'd7, 32'd5, rtype(1, 2, 3, 0, 'h20)), '0,
              exme(0, 1, 0, 0, 0, 1, 3, 32'd7, 32'd12));
        issue("addi_r1", idex(CTRL_ADDI, 32'h10, 32'h55, 32'd0, itype(8, 0, 1, 'h10)), '0,
              exme(0, 1, 0, 0, 0, 1, 1, 32'h55, 32'h10));
        issue("sub_fwd_exmem", idex(CTRL_R, 0, 32'd1, 32'h77, rtype(1, 2, 4, 0, 'h22)),
              memwb(0, 32'h99, 1, 1, 0),
              exme(0, 1, 0, 0, 0, 1, 4, 32'd1, 32'h0F));
        issue("add_fwd_memwb_load", idex(CTRL_R, 0, 32'd0, 32'd1, rtype(6, 7, 5, 0, 'h20)),
              memwb(1, 32'd3, 1, 7, 32'h100),
              exme(0, 1, 0, 0, 0, 1, 5, 32'h100, 32'h101));
        issue("lw_addr", idex(CTRL_LW, 32'd4, 32'd3, 32'd0, itype(35, 0, 8, 4)), '0,
              exme(0, 1, 0, 1, 1, 1, 8, 32'd3, 32'd4));
        issue("no_fwd_from_load", idex(CTRL_R, 0, 32'd0, 32'h20, rtype(8, 0, 9, 0, 'h20)), '0,
              exme(0, 1, 0, 0, 0, 1, 9, 32'd0, 32'h20));
        issue("add_overflow", idex(CTRL_R, 0, 32'd1, 32'h7FFF_FFFF, rtype(11, 12, 10, 0, 'h20)), '0,
              exme(1, 1, 0, 0, 0, 1, 10, 32'd1, 32'h8000_0000));
        issue("slt_neg", idex(CTRL_R, 0, 32'd3, 32'hFFFF_FFFB, rtype(14, 15, 13, 0, 'h2A)), '0,
              exme(0, 1, 0, 0, 0, 1, 13, 32'd3, 32'd1));
        issue("sll", idex(CTRL_R, 0, 32'd3, 32'd0, rtype(0, 17, 16, 4, 'h00)), '0,
              exme(0, 1, 0, 0, 0, 1, 16, 32'd3, 32'h30));
        issue("and", idex(CTRL_R, 0, 32'hFF00, 32'hF0F0, rtype(19, 20, 18, 0, 'h24)), '0,
              exme(0, 1, 0, 0, 0, 1, 18, 32'hFF00, 32'hF000));
        issue("sub_overflow", idex(CTRL_R, 0, 32'd1, 32'h8000_0000, rtype(22, 23, 21, 0, 'h22)), '0,
              exme(1, 1, 0, 0, 0, 1, 21, 32'd1, 32'h7FFF_FFFF));
        issue("slti", idex(CTRL_SLTI, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFE, itype(10, 25, 24, 'hFFFF)), '0,
              exme(0, 1, 0, 0, 0, 1, 24, 32'd9, 32'd1));

        runMult("mult_neg", idex(CTRL_MULT, 0, 32'd7, 32'hFFFF_FFFD, rtype(18, 19, 0, 0, 'h18)),
                exme(0, 1, 0, 0, 0, 0, 0, 32'd7, 32'hFFFF_FFEB));
        issue("mfhi_neg", idex(CTRL_R, 0, 0, 0, rtype(0, 0, 20, 0, 'h10)), '0,
              exme(0, 1, 0, 0, 0, 1, 20, 32'd0, 32'hFFFF_FFFF));
        issue("mflo_neg", idex(CTRL_R, 0, 0, 0, rtype(0, 0, 21, 0, 'h12)), '0,
              exme(0, 1, 0, 0, 0, 1, 21, 32'd0, 32'hFFFF_FFEB));

        runMult("multu_max", idex(CTRL_MULT, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rtype(18, 19, 0, 0, 'h19)),
                exme(0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0000_0001));
        issue("mfhi_multu", idex(CTRL_R, 0, 0, 0, rtype(0, 0, 20, 0, 'h10)), '0,
              exme(0, 1, 0, 0, 0, 1, 20, 32'd0, 32'hFFFF_FFFE));
        issue("mflo_multu", idex(CTRL_R, 0, 0, 0, rtype(0, 0, 21, 0, 'h12)), '0,
              exme(0, 1, 0, 0, 0, 1, 21, 32'd0, 32'h0000_0001));

        runMult("mult_minmin", idex(CTRL_MULT, 0, 32'h8000_0000, 32'h8000_0000, rtype(18, 19, 0, 0, 'h18)),
                exme(0, 1, 0, 0, 0, 0, 0, 32'h8000_0000, 32'd0));
        issue("mfhi_minmin", idex(CTRL_R, 0, 0, 0, rtype(0, 0, 20, 0, 'h10)), '0,
              exme(0, 1, 0, 0, 0, 1, 20, 32'd0, 32'h4000_0000));
        issue("mflo_minmin", idex(CTRL_R, 0, 0, 0, rtype(0, 0, 21, 0, 'h12)), '0,
              exme(0, 1, 0, 0, 0, 1, 21, 32'd0, 32'd0));

        // Abort a multiply ten cycles in
        IDEXReg  = idex(CTRL_MULT, 0, 32'd6, 32'd5, rtype(18, 19, 0, 0, 'h18));
        MEMWBReg = '0;
        #1;
        checkEq("abort_stall_before", exStall, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        checkEq("abort_stall", exStall, 1'b0);
        checkEq("abort_exme", EXMEReg, 75'd0);
        tick();
        reset = 1'b0;
        #1;
        issue("mfhi_after_reset", idex(CTRL_R, 0, 0, 0, rtype(0, 0, 20, 0, 'h10)), '0,
              exme(0, 1, 0, 0, 0, 1, 20, 32'd0, 32'd0));
        issue("mflo_after_reset", idex(CTRL_R, 0, 0, 0, rtype(0, 0, 21, 0, 'h12)), '0,
              exme(0, 1, 0, 0, 0, 1, 21, 32'd0, 32'd0));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
